// File: rtl/rom_fetch_if.sv
// ROM strobe/data bus plus the fetched-instruction valid/ready stream.
// The fetch engine is the master; the ROM and decode side form the slave.
interface rom_fetch_if #(
  parameter int ROM_DATASIZE = 32,
  parameter int ROM_ADRSIZE  = 5
) ();
  logic [ROM_ADRSIZE-1:0]  rom_adr;
  logic                    rom_oe;
  logic                    rom_cs;
  logic [ROM_DATASIZE-1:0] rom_data;
  logic [ROM_DATASIZE-1:0] instr;
  logic [ROM_ADRSIZE-1:0]  instr_adr;
  logic                    instr_valid;
  logic                    instr_ready;

  modport master (
    output rom_adr, rom_oe, rom_cs,
    output instr, instr_adr, instr_valid,
    input  rom_data, instr_ready
  );

  modport slave (
    input  rom_adr, rom_oe, rom_cs,
    input  instr, instr_adr, instr_valid,
    output rom_data, instr_ready
  );
endinterface

// File: rtl/rom_fetch.sv
// Sequential ROM fetch engine: drives ADR/OE/CS, captures DATA and
// hands each word with its address to decode over valid/ready.
module rom_fetch #(
  parameter int ROM_DATASIZE = 32,
  parameter int ROM_ADRSIZE  = 5,
  parameter int RD_WAIT      = 1,
  parameter int RESET_ADR    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   redirect,
  input  logic [ROM_ADRSIZE-1:0] redirect_adr,
  output logic                   busy,
  rom_fetch_if.master            bus
);
  localparam int WAIT = (RD_WAIT < 1) ? 1 : RD_WAIT;
  localparam int CW   = (WAIT > 1) ? $clog2(WAIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT - 1);
  localparam logic [ROM_ADRSIZE-1:0] RST_PC = ROM_ADRSIZE'(RESET_ADR);

  typedef enum logic [1:0] {IDLE, ADDR, READ, HOLD} state_t;

  state_t                  state, state_d;
  logic [ROM_ADRSIZE-1:0]  pc, pc_d;
  logic [ROM_ADRSIZE-1:0]  adr_d;
  logic [CW-1:0]           cnt, cnt_d;
  logic [ROM_DATASIZE-1:0] instr_d;
  logic [ROM_ADRSIZE-1:0]  iadr_d;
  logic                    valid_d;
  logic                    xfer;

  assign xfer = bus.instr_valid & bus.instr_ready;

  always_comb begin
    state_d = state;
    pc_d    = pc;
    cnt_d   = cnt;
    instr_d = bus.instr;
    iadr_d  = bus.instr_adr;
    valid_d = bus.instr_valid;
    unique case (state)
      IDLE: if (run) state_d = ADDR;
      ADDR: state_d = READ;
      READ: begin
        if (cnt == LAST) begin
          cnt_d   = '0;
          instr_d = bus.rom_data;
          iadr_d  = pc;
          valid_d = 1'b1;
          pc_d    = pc + ROM_ADRSIZE'(1);
          state_d = HOLD;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      HOLD: begin
        if (xfer) begin
          valid_d = 1'b0;
          state_d = run ? ADDR : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A redirect aborts whatever is in flight or held.
    if (redirect) begin
      pc_d    = redirect_adr;
      valid_d = 1'b0;
      cnt_d   = '0;
      state_d = run ? ADDR : IDLE;
    end
    adr_d = (state_d == ADDR) ? pc_d : bus.rom_adr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      pc              <= RST_PC;
      cnt             <= '0;
      bus.rom_adr     <= RST_PC;
      bus.rom_cs      <= 1'b1;
      bus.rom_oe      <= 1'b0;
      bus.instr       <= '0;
      bus.instr_adr   <= '0;
      bus.instr_valid <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state           <= state_d;
      pc              <= pc_d;
      cnt             <= cnt_d;
      bus.rom_adr     <= adr_d;
      bus.rom_cs      <= !((state_d == ADDR) || (state_d == READ));
      bus.rom_oe      <= (state_d == READ);
      bus.instr       <= instr_d;
      bus.instr_adr   <= iadr_d;
      bus.instr_valid <= valid_d;
      busy            <= (state_d != IDLE);
    end
  end
endmodule

// File: tb/tb_rom_fetch.sv
// Bench for rom_fetch: ROM model, expected-word queue, negedge monitor.
// Second instance with RD_WAIT=4 covers long reads and reset mid-read.
module tb_rom_fetch;
  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct {
    logic [AW-1:0] adr;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, run, redirect, busy;
  logic [AW-1:0] redirect_adr;
  logic          rst4, run4, redirect4, busy4;
  logic [AW-1:0] redirect_adr4;

  logic [DW-1:0] rom [32];
  exp_t          expq [$];
  exp_t          e_m;
  logic [AW-1:0] last_adr;
  logic [AW-1:0] old;
  int            errors = 0;
  int            checks = 0;
  int            n_xfer = 0;
  int            n, nx;

  rom_fetch_if #(.ROM_DATASIZE(DW), .ROM_ADRSIZE(AW)) bus ();
  rom_fetch_if #(.ROM_DATASIZE(DW), .ROM_ADRSIZE(AW)) bus4 ();

  rom_fetch #(
    .ROM_DATASIZE(DW), .ROM_ADRSIZE(AW), .RD_WAIT(1), .RESET_ADR(0)
  ) u_dut (
    .clk(clk), .rst(rst), .run(run), .redirect(redirect),
    .redirect_adr(redirect_adr), .busy(busy), .bus(bus.master)
  );

  rom_fetch #(
    .ROM_DATASIZE(DW), .ROM_ADRSIZE(AW), .RD_WAIT(4), .RESET_ADR(3)
  ) u_dut4 (
    .clk(clk), .rst(rst4), .run(run4), .redirect(redirect4),
    .redirect_adr(redirect_adr4), .busy(busy4), .bus(bus4.master)
  );

  // ROM returns the inverted word unless both selected and enabled.
  always_comb begin
    bus.rom_data = (bus.rom_oe && !bus.rom_cs) ?
                   rom[bus.rom_adr] : ~rom[bus.rom_adr];
    bus4.rom_data = (bus4.rom_oe && !bus4.rom_cs) ?
                    rom[bus4.rom_adr] : ~rom[bus4.rom_adr];
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic refill(input logic [AW-1:0] a);
    expq.delete();
    for (int i = 0; i < 256; i++) begin
      exp_t e;
      e.adr  = AW'(int'(a) + i);
      e.data = rom[e.adr];
      expq.push_back(e);
    end
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!bus.instr_valid && k < 20) begin
      step(1);
      k++;
    end
    chk("wait_valid", bus.instr_valid, 1);
  endtask

  task automatic wait_oe();
    int k = 0;
    while (!bus.rom_oe && k < 20) begin
      step(1);
      k++;
    end
    chk("wait_oe", bus.rom_oe, 1);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("oe_with_cs", bus.rom_oe & bus.rom_cs, 0);
      if (bus.instr_valid && bus.instr_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: got word %0h expected none", bus.instr);
        end else begin
          e_m = expq.pop_front();
          chk("sb_adr", bus.instr_adr, e_m.adr);
          chk("sb_data", bus.instr, e_m.data);
        end
        last_adr = bus.instr_adr;
        n_xfer++;
      end
    end
    if (!rst4) chk("oe_with_cs4", bus4.rom_oe & bus4.rom_cs, 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = $urandom;
    rst = 1; run = 0; redirect = 0; redirect_adr = '0;
    rst4 = 1; run4 = 0; redirect4 = 0; redirect_adr4 = '0;
    bus.instr_ready = 0;
    bus4.instr_ready = 0;
    step(2);
    chk("rst_adr", bus.rom_adr, 0);
    chk("rst_cs", bus.rom_cs, 1);
    chk("rst_oe", bus.rom_oe, 0);
    chk("rst_instr", bus.instr, 0);
    chk("rst_iadr", bus.instr_adr, 0);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_busy", busy, 0);

    rst = 0;
    refill(0);
    step(1);
    run = 1;
    bus.instr_ready = 1;
    n = 0;
    do begin step(1); n++; end while (!bus.instr_valid && n < 10);
    chk("first_latency", n, 3);
    n = 0;
    do begin step(1); n++; end while (!bus.instr_valid && n < 10);
    chk("period", n, 3);

    // Stall: word must hold while ready is low.
    wait_valid();
    bus.instr_ready = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("hold_valid", bus.instr_valid, 1);
      chk("hold_adr", bus.instr_adr, expq[0].adr);
      chk("hold_data", bus.instr, expq[0].data);
      chk("hold_cs", bus.rom_cs, 1);
      chk("hold_oe", bus.rom_oe, 0);
    end
    nx = n_xfer;
    bus.instr_ready = 1;
    step(1);
    chk("one_xfer", n_xfer, nx + 1);
    chk("after_xfer_valid", bus.instr_valid, 0);
    chk("next_fetch_busy", busy, 1);
    chk("next_fetch_adr", bus.rom_adr, expq[0].adr);

    // PC wrap 31 -> 0.
    redirect = 1; redirect_adr = 30;
    step(1);
    redirect = 0;
    refill(30);
    n = 0;
    while (bus.rom_adr != 0 && n < 30) begin step(1); n++; end
    chk("wrap_adr", bus.rom_adr, 0);
    chk("wrap_prev", last_adr, 31);

    // Redirect during READ.
    wait_oe();
    redirect = 1; redirect_adr = 12;
    step(1);
    redirect = 0;
    refill(12);
    chk("redir_valid", bus.instr_valid, 0);
    chk("redir_oe", bus.rom_oe, 0);
    wait_valid();
    chk("redir_read_adr", bus.instr_adr, 12);

    // Redirect coinciding with an accept.
    redirect = 1; redirect_adr = 12;
    step(1);
    redirect = 0;
    refill(12);
    chk("redir_acc_valid", bus.instr_valid, 0);
    wait_valid();
    chk("redir_acc_adr", bus.instr_adr, 12);

    // Run drops mid-read.
    step(1);
    wait_oe();
    old = expq[0].adr;
    run = 0;
    wait_valid();
    chk("stop_adr", bus.instr_adr, old);
    step(1);
    chk("stop_busy", busy, 0);
    chk("stop_cs", bus.rom_cs, 1);
    chk("stop_oe", bus.rom_oe, 0);
    step(3);
    chk("stop_idle", busy, 0);
    run = 1;
    wait_valid();
    chk("resume_adr", bus.instr_adr, AW'(int'(old) + 1));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bus.instr_ready = ($urandom_range(0, 3) != 0);
      run = ($urandom_range(0, 9) != 0);
      redirect = ($urandom_range(0, 11) == 0);
      redirect_adr = AW'($urandom);
      step(1);
      if (redirect) refill(redirect_adr);
      redirect = 0;
    end
    chk("random_traffic", n_xfer > 40, 1);
    run = 0;

    // Long-read instance.
    rst4 = 0;
    run4 = 1;
    bus4.instr_ready = 1;
    n = 0;
    do begin step(1); n++; end while (!bus4.instr_valid && n < 20);
    chk("w4_latency", n, 6);
    chk("w4_adr", bus4.instr_adr, 3);
    chk("w4_data", bus4.instr, rom[3]);
    n = 0;
    do begin step(1); n++; end while (!bus4.instr_valid && n < 20);
    chk("w4_period", n, 6);
    chk("w4_adr2", bus4.instr_adr, 4);
    n = 0;
    while (!bus4.rom_oe && n < 20) begin step(1); n++; end
    step(2);
    chk("w4_mid_read", bus4.rom_oe, 1);
    rst4 = 1;
    step(1);
    chk("w4_rst_busy", busy4, 0);
    chk("w4_rst_adr", bus4.rom_adr, 3);
    chk("w4_rst_cs", bus4.rom_cs, 1);
    chk("w4_rst_oe", bus4.rom_oe, 0);
    chk("w4_rst_instr", bus4.instr, 0);
    chk("w4_rst_iadr", bus4.instr_adr, 0);
    chk("w4_rst_valid", bus4.instr_valid, 0);
    rst4 = 0;
    n = 0;
    do begin step(1); n++; end while (!bus4.instr_valid && n < 20);
    chk("w4_rst_latency", n, 6);
    chk("w4_rst_fetch", bus4.instr_adr, 3);

    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
